// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage for the KGP-RISC pipeline.
// Owns the PC and keeps at most one request outstanding to instruction
// memory. Each fetched word goes to the IF/ID register with its PC+1.
// Hazard stalls freeze the IF outputs. Branch/jump redirects flush the
// stage and refetch from the target PC.
// Optional macro FETCH_PERF_CNT_EN builds the fetch and stall counters.
// Without it, both counter ports are tied to zero.
module inst_fetch_unit #(
    parameter int              PC_W     = 10,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   npc_out,
    output logic              inst_valid,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Architectural and control state
    state_t              state;
    logic [PC_W-1:0]     pc;
    logic [INST_W-1:0]   hold_buf;
    logic                discard;

    // Next-state values
    state_t              state_n;
    logic [PC_W-1:0]     pc_n;
    logic [INST_W-1:0]   hold_n;
    logic                discard_n;
    logic                req_n;
    logic [PC_W-1:0]     addr_n;
    logic [INST_W-1:0]   inst_n;
    logic [PC_W-1:0]     npc_n;
    logic                valid_n;

    logic [PC_W-1:0]     pc_inc;

    // PC arithmetic wraps naturally at PC_W bits.
    assign pc_inc = pc + 1'b1;

    // Next-state, PC and IF/ID output selection
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        hold_n    = hold_buf;
        discard_n = discard;
        // Non-delivery cycle: a bubble when running, frozen when stalled.
        if (stall) begin
            inst_n  = inst_out;
            npc_n   = npc_out;
            valid_n = inst_valid;
        end else begin
            inst_n  = '0;
            npc_n   = npc_out;
            valid_n = 1'b0;
        end

        if (redirect_en) begin
            // Flush. This beats stall, and any held word is dropped.
            pc_n    = redirect_pc;
            inst_n  = '0;
            valid_n = 1'b0;
            hold_n  = '0;
            case (state)
                S_ISSUE: begin
                    // If a request is already on the bus, its reply is stale.
                    if (imem_req) begin
                        discard_n = 1'b1;
                        state_n   = S_WAIT;
                    end else begin
                        state_n   = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        // The reply arriving now is simply dropped.
                        discard_n = 1'b0;
                        state_n   = S_ISSUE;
                    end else begin
                        // The reply is still in flight; swallow it when it lands.
                        discard_n = 1'b1;
                        state_n   = S_WAIT;
                    end
                end
                default: begin
                    state_n = S_ISSUE;
                end
            endcase
        end else begin
            case (state)
                S_ISSUE: begin
                    // The first ISSUE cycle after reset raises the request.
                    // Later ISSUE cycles already have it on the bus.
                    if (imem_req) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard_n = 1'b0;
                            state_n   = S_ISSUE;
                        end else if (!stall) begin
                            inst_n  = imem_rdata;
                            npc_n   = pc_inc;
                            valid_n = 1'b1;
                            pc_n    = pc_inc;
                            state_n = S_ISSUE;
                        end else begin
                            hold_n  = imem_rdata;
                            state_n = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // Any stray rvalid here is ignored.
                    if (!stall) begin
                        inst_n  = hold_buf;
                        npc_n   = pc_inc;
                        valid_n = 1'b1;
                        pc_n    = pc_inc;
                        hold_n  = '0;
                        state_n = S_ISSUE;
                    end
                end
                default: begin
                    state_n = S_ISSUE;
                end
            endcase
        end

        // The request is registered, so it is high for the whole ISSUE cycle.
        req_n  = (state_n == S_ISSUE);
        addr_n = req_n ? pc_n : imem_addr;
    end

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_ISSUE;
            pc         <= RESET_PC;
            hold_buf   <= '0;
            discard    <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            inst_out   <= '0;
            npc_out    <= '0;
            inst_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            hold_buf   <= hold_n;
            discard    <= discard_n;
            imem_req   <= req_n;
            imem_addr  <= addr_n;
            inst_out   <= inst_n;
            npc_out    <= npc_n;
            inst_valid <= valid_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for deliveries and stall cycles without a redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (inst_valid && (perf_fetch_cnt != 16'hFFFF)) begin
                perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
            end
            if (stall && !redirect_en && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit. It uses a behavioural instruction
// memory whose latency can be set and which returns (0x1000_0000 | addr).
module tb_inst_fetch_unit;

    localparam int PC_W   = 10;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_rvalid = 1'b0;
    logic [INST_W-1:0] imem_rdata = '0;
    logic              stall = 1'b0;
    logic              redirect_en = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic [INST_W-1:0] inst_out;
    logic [PC_W-1:0]   npc_out;
    logic              inst_valid;
    logic [15:0]       perf_fetch_cnt;
    logic [15:0]       perf_stall_cnt;

    int checks = 0;
    int fails  = 0;

    inst_fetch_unit #(.PC_W(PC_W), .INST_W(INST_W), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .inst_out(inst_out), .npc_out(npc_out), .inst_valid(inst_valid),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: a reply comes lat cycles after the request is seen.
    int              lat = 1;
    logic            pend = 1'b0;
    int              cnt = 0;
    logic [PC_W-1:0] paddr = '0;
    always @(posedge clk) begin
        imem_rvalid <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= 32'h1000_0000 | {22'b0, paddr};
                    pend        <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (imem_req) begin
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= 32'h1000_0000 | {22'b0, imem_addr};
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= imem_addr;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; lat = 1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({imem_req, imem_addr, inst_valid, inst_out, npc_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: req=%0b addr=%h valid=%0b inst=%h npc=%h, required all zero",
                     imem_req, imem_addr, inst_valid, inst_out, npc_out);
        end
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== 32'h0) begin
            fails++;
            $display("FAIL reset_perf: fetch=%0d stall=%0d, required 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        checks++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 10'h000, 1'b0}) begin
            fails++;
            $display("FAIL seq_first_req: req=%0b addr=%h valid=%0b, required 1/000/0", imem_req, imem_addr, inst_valid);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({imem_req, inst_valid, inst_out} !== {1'b0, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL seq_bubble[%0d]: req=%0b valid=%0b inst=%h, required 0/0/0", i, imem_req, inst_valid, inst_out);
            end
            step();
            checks++;
            if ({inst_valid, inst_out, npc_out, imem_req, imem_addr} !==
                {1'b1, 32'h1000_0000 + i, 10'(i + 1), 1'b1, 10'(i + 1)}) begin
                fails++;
                $display("FAIL seq_deliver[%0d]: valid=%0b inst=%h npc=%h req=%0b addr=%h, required 1/%h/%h/1/%h",
                         i, inst_valid, inst_out, npc_out, imem_req, imem_addr, 32'h1000_0000 + i, i + 1, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        bit found = 0;
        apply_reset();
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (imem_req && imem_addr == 10'h003) found = 1;
        end
        checks++;
        if (!found || {inst_valid, inst_out, npc_out} !== {1'b1, 32'h1000_0002, 10'h003}) begin
            fails++;
            $display("FAIL stall_setup: found=%0b valid=%0b inst=%h npc=%h, required 1/1/10000002/003",
                     found, inst_valid, inst_out, npc_out);
        end
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({inst_valid, inst_out, npc_out, imem_req} !== {1'b1, 32'h1000_0002, 10'h003, 1'b0}) begin
                fails++;
                $display("FAIL stall_frozen[%0d]: valid=%0b inst=%h npc=%h req=%0b, required 1/10000002/003/0",
                         k, inst_valid, inst_out, npc_out, imem_req);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out, imem_req, imem_addr} !== {1'b1, 32'h1000_0003, 10'h004, 1'b1, 10'h004}) begin
            fails++;
            $display("FAIL stall_release: valid=%0b inst=%h npc=%h req=%0b addr=%h, required 1/10000003/004/1/004",
                     inst_valid, inst_out, npc_out, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        apply_reset();
        lat = 4;
        step();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 10'h000}) begin
            fails++;
            $display("FAIL rdw_req0: req=%0b addr=%h, required 1/000", imem_req, imem_addr);
        end
        step();
        redirect_en = 1'b1; redirect_pc = 10'h200;
        step();
        redirect_en = 1'b0; lat = 1;
        checks++;
        if ({imem_req, inst_valid, inst_out} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL rdw_flush: req=%0b valid=%0b inst=%h, required 0/0/0", imem_req, inst_valid, inst_out);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (imem_req) begin
                found = 1;
            end else begin
                checks++;
                if ({inst_valid, inst_out} !== {1'b0, 32'h0}) begin
                    fails++;
                    $display("FAIL rdw_no_stale[%0d]: valid=%0b inst=%h, required 0/0", k, inst_valid, inst_out);
                end
            end
        end
        checks++;
        if (!found || imem_addr !== 10'h200 || inst_valid !== 1'b0) begin
            fails++;
            $display("FAIL rdw_refetch: found=%0b addr=%h valid=%0b, required 1/200/0", found, imem_addr, inst_valid);
        end
        step();
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out, imem_req, imem_addr} !== {1'b1, 32'h1000_0200, 10'h201, 1'b1, 10'h201}) begin
            fails++;
            $display("FAIL rdw_deliver: valid=%0b inst=%h npc=%h req=%0b addr=%h, required 1/10000200/201/1/201",
                     inst_valid, inst_out, npc_out, imem_req, imem_addr);
        end
    endtask

    // Redirect together with stall and an arriving response, while outputs are held.
    task automatic test_redirect_stall_rvalid();
        stall = 1'b1;
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out} !== {1'b1, 32'h1000_0200, 10'h201}) begin
            fails++;
            $display("FAIL rsr_hold: valid=%0b inst=%h npc=%h, required 1/10000200/201", inst_valid, inst_out, npc_out);
        end
        redirect_en = 1'b1; redirect_pc = 10'h155;
        step();
        redirect_en = 1'b0; stall = 1'b0;
        checks++;
        if ({inst_valid, inst_out, npc_out, imem_req, imem_addr} !== {1'b0, 32'h0, 10'h201, 1'b1, 10'h155}) begin
            fails++;
            $display("FAIL rsr_flush: valid=%0b inst=%h npc=%h req=%0b addr=%h, required 0/0/201/1/155",
                     inst_valid, inst_out, npc_out, imem_req, imem_addr);
        end
        step();
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out} !== {1'b1, 32'h1000_0155, 10'h156}) begin
            fails++;
            $display("FAIL rsr_deliver: valid=%0b inst=%h npc=%h, required 1/10000155/156", inst_valid, inst_out, npc_out);
        end
    endtask

    // Redirect during ISSUE to the top of the PC space, then wrap to zero.
    task automatic test_wrap();
        redirect_en = 1'b1; redirect_pc = 10'h3FF;
        step();
        redirect_en = 1'b0;
        checks++;
        if ({imem_req, inst_valid, inst_out} !== {1'b0, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL wrap_flush: req=%0b valid=%0b inst=%h, required 0/0/0", imem_req, inst_valid, inst_out);
        end
        step();
        checks++;
        if ({imem_req, imem_addr, inst_valid, inst_out} !== {1'b1, 10'h3FF, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL wrap_req: req=%0b addr=%h valid=%0b inst=%h, required 1/3ff/0/0", imem_req, imem_addr, inst_valid, inst_out);
        end
        step();
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out, imem_req, imem_addr} !== {1'b1, 32'h1000_03FF, 10'h000, 1'b1, 10'h000}) begin
            fails++;
            $display("FAIL wrap_deliver: valid=%0b inst=%h npc=%h req=%0b addr=%h, required 1/100003ff/000/1/000",
                     inst_valid, inst_out, npc_out, imem_req, imem_addr);
        end
        step();
        step();
        checks++;
        if ({inst_valid, inst_out, npc_out} !== {1'b1, 32'h1000_0000, 10'h001}) begin
            fails++;
            $display("FAIL wrap_next: valid=%0b inst=%h npc=%h, required 1/10000000/001", inst_valid, inst_out, npc_out);
        end
    endtask

    task automatic test_reset_midop();
        reset = 1'b1;
        step();
        checks++;
        if ({imem_req, imem_addr, inst_valid, inst_out, npc_out} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: req=%0b addr=%h valid=%0b inst=%h npc=%h, required all zero",
                     imem_req, imem_addr, inst_valid, inst_out, npc_out);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 10'h000}) begin
            fails++;
            $display("FAIL midreset_restart: req=%0b addr=%h, required 1/000", imem_req, imem_addr);
        end
    endtask

    task automatic test_perf();
        logic [15:0] exp_f, exp_s;
`ifdef FETCH_PERF_CNT_EN
        exp_f = 16'd5; exp_s = 16'd7;
`else
        exp_f = 16'd0; exp_s = 16'd0;
`endif
        apply_reset();
        step();
        step();
        stall = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            checks++;
            if (inst_valid !== 1'b0) begin
                fails++;
                $display("FAIL perf_stall_valid[%0d]: valid=%0b, required 0", k, inst_valid);
            end
        end
        stall = 1'b0;
        repeat (10) step();
        checks++;
        if ({perf_fetch_cnt, perf_stall_cnt} !== {exp_f, exp_s}) begin
            fails++;
            $display("FAIL perf_counts: fetch=%0d stall=%0d, required %0d/%0d", perf_fetch_cnt, perf_stall_cnt, exp_f, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_wait();
        test_redirect_stall_rvalid();
        test_wrap();
        test_reset_midop();
        test_perf();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
